// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM BIST sequencer: state encoding, pattern
// select codes and the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) helpers.
package sram_bist_pkg;

    localparam int unsigned LFSR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] PAT_ADR   = 2'd0;
    localparam logic [1:0] PAT_CHK   = 2'd1;
    localparam logic [1:0] PAT_CONST = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 8'h01;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [LFSR_W-1:0] lfsr_init(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_ZERO_SUB : s;
    endfunction

    // Shift left, feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_bist_patgen.sv
// Pattern generator: combinational pattern mux plus the LFSR register.
// Load has priority over advance so one strobe pair can rewind the sequence.
module sram_bist_patgen
    import sram_bist_pkg::*;
#(
    parameter int unsigned DAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pat_sel,
    input  logic [DAT_W-1:0]  seed,
    input  logic [DAT_W-1:0]  load_seed,
    input  logic [7:0]        adr_lo,
    input  logic              load,
    input  logic              advance,
    input  logic              invert,
    output logic [DAT_W-1:0]  pattern_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] raw_c;

    // LFSR next value: reload from seed or step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = lfsr_init(LFSR_W'(load_seed));
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR register; reset loads the seed so it is never zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q <= lfsr_init(LFSR_W'(load_seed));
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Pattern select with optional complement.
    always_comb begin
        raw_c = '0;
        case (pat_sel)
            PAT_ADR:   raw_c = adr_lo;
            PAT_CHK:   raw_c = adr_lo[0] ? 8'hAA : 8'h55;
            PAT_CONST: raw_c = LFSR_W'(seed);
            PAT_LFSR:  raw_c = lfsr_q;
            default:   raw_c = '0;
        endcase
        pattern_c = DAT_W'(invert ? ~raw_c : raw_c);
    end

endmodule

// File: rtl/sram_bist_seq.sv
// SRAM BIST sequencer: writes a pattern over 0..ADR_LAST, reads it back and
// compares, reporting pass/fail, a saturating error count and first bad address.
// Optional feature macro SRAM_BIST_INV_PASS_EN adds a second complemented pass.
module sram_bist_seq
    import sram_bist_pkg::*;
#(
    parameter int unsigned ADR_W    = 19,
    parameter int unsigned DAT_W    = 8,
    parameter int unsigned ADR_LAST = 32'h7FFFF,
    parameter int unsigned ERR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pat_sel,
    input  logic [DAT_W-1:0]  seed,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DAT_W-1:0]  mem_wdat,
    input  logic [DAT_W-1:0]  mem_rdat,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADR_W-1:0]  first_err_adr
);

    state_e             state_q, state_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [1:0]         pat_q, pat_d;
    logic [DAT_W-1:0]   seed_q, seed_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [DAT_W-1:0]   wdat_q, wdat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [ADR_W-1:0]   first_q, first_d;
    logic               lfsr_load_c, lfsr_adv_c, invert_c, last_c;
    logic [DAT_W-1:0]   load_seed_c, pattern_c;
`ifdef SRAM_BIST_INV_PASS_EN
    logic               phase_q, phase_d;
    assign invert_c = phase_q;
`else
    assign invert_c = 1'b0;
`endif

    // Live switch seed is used when idle or in reset; the latched one mid-run.
    assign load_seed_c = (!reset || state_q == ST_IDLE) ? seed : seed_q;
    assign last_c      = (adr_q == ADR_W'(ADR_LAST));

    sram_bist_patgen #(.DAT_W(DAT_W)) u_patgen (
        .clk       (clk),
        .reset     (reset),
        .pat_sel   (pat_q),
        .seed      (seed_q),
        .load_seed (load_seed_c),
        .adr_lo    (adr_q[7:0]),
        .load      (lfsr_load_c),
        .advance   (lfsr_adv_c),
        .invert    (invert_c),
        .pattern_c (pattern_c)
    );

    // Next-state, handshake and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        pat_d       = pat_q;
        seed_d      = seed_q;
        req_d       = req_q;
        we_d        = we_q;
        wdat_d      = wdat_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;
        lfsr_load_c = 1'b0;
        lfsr_adv_c  = 1'b0;
`ifdef SRAM_BIST_INV_PASS_EN
        phase_d     = phase_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_d       = pat_sel;
                    seed_d      = seed;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    first_d     = '0;
                    adr_d       = '0;
                    busy_d      = 1'b1;
                    lfsr_load_c = 1'b1;
                    state_d     = ST_WR;
`ifdef SRAM_BIST_INV_PASS_EN
                    phase_d     = 1'b0;
`endif
                end
            end
            ST_WR: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b1;
                    wdat_d = pattern_c;
                end else if (mem_ack) begin
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    lfsr_adv_c = 1'b1;
                    if (last_c) begin
                        adr_d       = '0;
                        lfsr_load_c = 1'b1;
                        state_d     = ST_RD;
                    end else begin
                        adr_d = adr_q + ADR_W'(1);
                    end
                end
            end
            ST_RD: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    we_d  = 1'b0;
                end else if (mem_ack) begin
                    req_d      = 1'b0;
                    lfsr_adv_c = 1'b1;
                    if (mem_rdat != pattern_c) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (err_q == '0) begin
                            first_d = adr_q;
                        end
                    end
                    if (last_c) begin
`ifdef SRAM_BIST_INV_PASS_EN
                        if (!phase_q) begin
                            phase_d     = 1'b1;
                            adr_d       = '0;
                            lfsr_load_c = 1'b1;
                            state_d     = ST_WR;
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        adr_d = adr_q + ADR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            pat_q   <= '0;
            seed_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
`ifdef SRAM_BIST_INV_PASS_EN
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            pat_q   <= pat_d;
            seed_q  <= seed_d;
            req_q   <= req_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
`ifdef SRAM_BIST_INV_PASS_EN
            phase_q <= phase_d;
`endif
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_adr       = adr_q;
    assign mem_wdat      = wdat_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_adr = first_q;

endmodule

// File: tb/tb_sram_bist_seq.sv
// Bench for sram_bist_seq with ADR_LAST=15 and a small SRAM responder model.
// Honours SRAM_BIST_INV_PASS_EN for the two-pass build.
module tb_sram_bist_seq;

    localparam int unsigned ADR_W = 19;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned LAST  = 15;
`ifdef SRAM_BIST_INV_PASS_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       pat_sel = 2'd0;
    logic [7:0]       seed = 8'h00;
    logic             mem_req, mem_we, mem_ack;
    logic [ADR_W-1:0] mem_adr, first_err_adr;
    logic [7:0]       mem_wdat;
    logic [7:0]       mem_rdat = 8'h00;
    logic             busy, done, pass;
    logic [ERR_W-1:0] err_cnt;

    sram_bist_seq #(.ADR_W(ADR_W), .DAT_W(DAT_W), .ADR_LAST(LAST), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .pat_sel(pat_sel), .seed(seed),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat), .mem_ack(mem_ack), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_adr(first_err_adr)
    );

    // Second instance: tiny error counter to exercise saturation.
    logic             start2 = 1'b0;
    logic             req2, we2, busy2, done2, pass2;
    logic             ack2 = 1'b0;
    logic [ADR_W-1:0] adr2, first2;
    logic [7:0]       wdat2;
    logic [3:0]       err2;
    int               w2 = 0;

    sram_bist_seq #(.ADR_W(ADR_W), .DAT_W(DAT_W), .ADR_LAST(20), .ERR_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start2), .pat_sel(2'd1), .seed(8'h00),
        .mem_req(req2), .mem_we(we2), .mem_adr(adr2), .mem_wdat(wdat2),
        .mem_rdat(8'hF0), .mem_ack(ack2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .first_err_adr(first2)
    );

    // Responder for the saturation instance: always returns 0xF0.
    always @(posedge clk) begin
        ack2 <= 1'b0;
        if (!req2 || ack2) w2 <= 0;
        else if (w2 == 0) w2 <= 1;
        else begin w2 <= 0; ack2 <= 1'b1; end
    end

    // SRAM model: ack two cycles after req, with selectable read faults.
    logic [7:0]       mem [0:15];
    int               fault = 0;
    logic             log_clr = 1'b0;
    logic             stray_ack = 1'b0;
    logic             mdl_ack = 1'b0;
    int               wcnt = 0;
    int               n_wr = 0, n_rd = 0;
    logic [7:0]       wr_dat [0:63];
    logic [ADR_W-1:0] wr_adr [0:63];
    logic [ADR_W-1:0] rd_adr [0:63];

    assign mem_ack = mdl_ack | stray_ack;

    function automatic logic [7:0] rd_val(input int f, input logic [3:0] a, input logic [7:0] d);
        if (f == 1 && a == 4'd5) return d & 8'hF7;
        if (f == 2) return 8'hF0;
        return d;
    endfunction

    always @(posedge clk) begin
        mdl_ack <= 1'b0;
        if (log_clr) begin
            n_wr <= 0; n_rd <= 0; wcnt <= 0;
        end else if (!mem_req || mem_ack) begin
            wcnt <= 0;
        end else if (wcnt == 0) begin
            wcnt <= 1;
        end else begin
            wcnt    <= 0;
            mdl_ack <= 1'b1;
            if (mem_we) begin
                mem[mem_adr[3:0]] <= mem_wdat;
                if (n_wr < 64) begin wr_dat[n_wr] <= mem_wdat; wr_adr[n_wr] <= mem_adr; end
                n_wr <= n_wr + 1;
            end else begin
                mem_rdat <= rd_val(fault, mem_adr[3:0], mem[mem_adr[3:0]]);
                if (n_rd < 64) rd_adr[n_rd] <= mem_adr;
                n_rd <= n_rd + 1;
            end
        end
    end

    // Reference pattern model.
    function automatic logic [7:0] m_lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] m_pat(input logic [1:0] p, input logic [7:0] s,
                                         input int a, input logic [7:0] l);
        logic [31:0] av;
        av = a;
        case (p)
            2'd0:    return av[7:0];
            2'd1:    return av[0] ? 8'hAA : 8'h55;
            2'd2:    return s;
            default: return l;
        endcase
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] pat;
        logic [7:0] seed;
        int         fault;
        int         err;
        int         first;
        logic       pass;
    } vec_t;

    vec_t vecs [7];

    // One full run with a stray start mid-run, then result and traffic checks.
    task automatic run(input int v);
        int         got, bad, k;
        logic [7:0] l, e;
        pat_sel = vecs[v].pat; seed = vecs[v].seed; fault = vecs[v].fault;
        log_clr = 1'b1; tick(); log_clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        chk($sformatf("busy_after_start v%0d", v), 32'(busy), 1);
        chk($sformatf("done_cleared v%0d", v), 32'(done), 0);
        chk($sformatf("err_cleared v%0d", v), 32'(err_cnt), 0);
        repeat (6) tick();
        pat_sel = ~vecs[v].pat; seed = ~vecs[v].seed; start = 1'b1; tick(); start = 1'b0;
        pat_sel = vecs[v].pat; seed = vecs[v].seed;
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (done) begin got = 1; break; end
        end
        chk($sformatf("done_timeout v%0d", v), 32'(got), 1);
        chk($sformatf("busy_at_done v%0d", v), 32'(busy), 0);
        chk($sformatf("pass v%0d", v), 32'(pass), 32'(vecs[v].pass));
        chk($sformatf("err_cnt v%0d", v), 32'(err_cnt), 32'(vecs[v].err));
        chk($sformatf("first_err_adr v%0d", v), 32'(first_err_adr), 32'(vecs[v].first));
        chk($sformatf("n_wr v%0d", v), 32'(n_wr), 32'(16 * NPH));
        chk($sformatf("n_rd v%0d", v), 32'(n_rd), 32'(16 * NPH));
        bad = 0;
        for (int ph = 0; ph < NPH; ph++) begin
            l = (vecs[v].seed == 8'h00) ? 8'h01 : vecs[v].seed;
            for (int a = 0; a <= int'(LAST); a++) begin
                k = ph * 16 + a;
                e = m_pat(vecs[v].pat, vecs[v].seed, a, l) ^ ((ph == 1) ? 8'hFF : 8'h00);
                if (wr_dat[k] !== e || wr_adr[k] !== ADR_W'(a) || rd_adr[k] !== ADR_W'(a)) bad++;
                l = m_lfsr_next(l);
            end
        end
        chk($sformatf("traffic_seq_bad v%0d", v), 32'(bad), 0);
    endtask

    initial begin
        int got;
        // pat, seed, fault, err, first, pass
        vecs[0] = '{2'd0, 8'h00, 0, 0, 0, 1'b1};
        vecs[1] = '{2'd3, 8'h00, 0, 0, 0, 1'b1};
        vecs[2] = '{2'd2, 8'hAA, 1, 1, 5, 1'b0};
        vecs[3] = '{2'd1, 8'h00, 2, 16 * NPH, 0, 1'b0};
`ifdef SRAM_BIST_INV_PASS_EN
        vecs[4] = '{2'd0, 8'h00, 1, 1, 5, 1'b0};
`else
        vecs[4] = '{2'd0, 8'h00, 1, 0, 0, 1'b1};
`endif
        vecs[5] = '{2'd2, 8'h08, 1, 1, 5, 1'b0};
        vecs[6] = '{2'd3, 8'h5A, 0, 0, 0, 1'b1};

        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_adr", 32'(mem_adr), 0);
        chk("rst_mem_wdat", 32'(mem_wdat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_first_err_adr", 32'(first_err_adr), 0);
        reset = 1'b1;
        tick();

        start2 = 1'b1; tick(); start2 = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run(v);
            if (v == 1) chk("lfsr_zero_seed_first", 32'(wr_dat[0]), 32'h01);
        end

        // Ack with no outstanding request must not disturb idle results.
        stray_ack = 1'b1; tick(); stray_ack = 1'b0; tick(); tick();
        chk("stray_ack_req", 32'(mem_req), 0);
        chk("stray_ack_busy", 32'(busy), 0);
        chk("stray_ack_done", 32'(done), 1);
        chk("stray_ack_err", 32'(err_cnt), 0);

        chk("sat_done", 32'(done2), 1);
        chk("sat_err_cnt", 32'(err2), 32'hF);
        chk("sat_first", 32'(first2), 0);
        chk("sat_pass", 32'(pass2), 0);

        // Reset in the middle of the write phase at address 7.
        pat_sel = 2'd2; seed = 8'h3C; fault = 2;
        start = 1'b1; tick(); start = 1'b0;
        got = 0;
        for (int i = 0; i < 500; i++) begin
            if (mem_req && mem_we && mem_adr == ADR_W'(7)) begin got = 1; break; end
            tick();
        end
        chk("mid_reset_reach_adr7", 32'(got), 1);
        reset = 1'b0; tick();
        chk("mid_reset_mem_req", 32'(mem_req), 0);
        chk("mid_reset_busy", 32'(busy), 0);
        chk("mid_reset_mem_we", 32'(mem_we), 0);
        chk("mid_reset_mem_adr", 32'(mem_adr), 0);
        chk("mid_reset_mem_wdat", 32'(mem_wdat), 0);
        chk("mid_reset_done", 32'(done), 0);
        chk("mid_reset_err", 32'(err_cnt), 0);
        reset = 1'b1; tick(); tick();
        chk("post_reset_idle_req", 32'(mem_req), 0);
        run(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
